// File: rtl/uart_pkg.sv
// uart_pkg
//   Types and constants shared by the UART receive and transmit controllers.
//   rx_state_t        : sequencer state encoding (IDLE/START/DATA/PARITY/STOP).
//   MIN_SCALER_DEFAULT: smallest legal prescaler divide value.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int unsigned MIN_SCALER_DEFAULT = 4;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2
//   Two-flop synchroniser for a single asynchronous bit.
//   Parameter RstVal: value both stages take in reset (line idle level).
//   Ports:
//     i_clk   : clock
//     i_rst_n : synchronous active-low reset
//     i_d     : asynchronous input
//     o_q     : synchronised output (two cycles of latency)
module uart_sync2 #(
  parameter logic RstVal = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge value of its neighbour; blocking here would collapse
  // the two stages into one.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      meta <= RstVal;
      o_q  <= RstVal;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Receive-side sequencer for the UART bit-rate prescaler. Detects a start
//   edge on the synchronised RX line, starts/clears the prescaler, samples
//   start, data (LSB first), optional parity and stop bits on the prescaler's
//   halfway pulse, and hands the assembled word to the host over valid/ready
//   with framing-error and sticky overrun reporting.
//
//   Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the
//   data bits plus the i_parity_odd / o_parity_err ports).
//
//   Ports:
//     i_clk, i_rst_n : clock, synchronous active-low reset
//     i_rx           : asynchronous serial line, idles high
//     i_scaler       : prescaler divide value; reception needs >= MinScaler
//     i_half         : prescaler halfway pulse (sample point)
//     i_strobe       : prescaler end-of-bit pulse (sanity checking only)
//     o_presc_en     : prescaler enable
//     o_presc_clr    : one-cycle prescaler clear on a start edge
//     o_data/o_valid/i_ready : received word handshake
//     o_frame_err    : stop bit sampled low, qualified by o_valid
//     i_parity_odd   : (macro) 1 = odd parity expected
//     o_parity_err   : (macro) parity mismatch, qualified by o_valid
//     o_overrun      : sticky, a completed frame was dropped; clears on transfer
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DataBits  = 8,
  parameter int unsigned MinScaler = MIN_SCALER_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_rx,
  input  logic [15:0]         i_scaler,
  input  logic                i_half,
  input  logic                i_strobe,
  output logic                o_presc_en,
  output logic                o_presc_clr,
  output logic [DataBits-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_frame_err,
`ifdef UART_RX_PARITY_EN
  input  logic                i_parity_odd,
  output logic                o_parity_err,
`endif
  output logic                o_overrun
);

  localparam int unsigned     CntW    = $clog2(DataBits);
  localparam logic [CntW-1:0] LastBit = CntW'(DataBits - 1);

  // ---------------------------------------------------------------------------
  // Line conditioning and start-edge detect
  // ---------------------------------------------------------------------------
  logic rx_s;
  logic rx_q;
  logic fall;
  logic scaler_ok;

  uart_sync2 #(.RstVal(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) rx_q <= 1'b1;
    else          rx_q <= rx_s;
  end

  assign fall      = rx_q && !rx_s;
  assign scaler_ok = (i_scaler >= 16'(MinScaler));

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  rx_state_t       state_q, state_d;
  logic [CntW-1:0] bit_cnt_q;
  logic            clr_d;
  logic            complete;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every signal driven here gets its default before the case, so no
  // path through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    clr_d    = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall && scaler_ok) begin
          clr_d   = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        // Line back high at mid-bit: it was a glitch, not a start bit.
        if (i_half) state_d = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (i_half && (bit_cnt_q == LastBit)) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
      ST_PARITY: begin
        if (i_half) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (i_half) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and host handshake (all outputs registered)
  // ---------------------------------------------------------------------------
  logic [DataBits-1:0] shift_q;
  logic                xfer;
  logic                accept_new;

  assign xfer       = o_valid && i_ready;
  // A completing frame may replace the held word only if that word is gone
  // or leaves in this very cycle.
  assign accept_new = !o_valid || i_ready;

`ifdef UART_RX_PARITY_EN
  logic parity_bit_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      parity_bit_q <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      if (state_q == ST_PARITY && i_half) parity_bit_q <= rx_s;
      if (complete && accept_new)
        o_parity_err <= ((^{shift_q, parity_bit_q}) != i_parity_odd);
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      o_presc_clr <= 1'b0;
      o_presc_en  <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_presc_clr <= clr_d;
      // Follows the state register, so enable rises the cycle after the clear.
      o_presc_en  <= (state_q != ST_IDLE);

      if (state_q == ST_START && i_half) bit_cnt_q <= '0;
      if (state_q == ST_DATA && i_half) begin
        shift_q   <= {rx_s, shift_q[DataBits-1:1]};
        bit_cnt_q <= bit_cnt_q + CntW'(1);
      end

      if (complete && accept_new) begin
        o_data      <= shift_q;
        o_frame_err <= !rx_s;
        o_valid     <= 1'b1;
      end else if (xfer) begin
        o_valid <= 1'b0;
      end

      if (xfer)                    o_overrun <= 1'b0;
      if (complete && !accept_new) o_overrun <= 1'b1;
    end
  end

  // The prescaler's halfway and end-of-bit pulses are never coincident.
  assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_half && i_strobe));

endmodule
